// File: rtl/pkg_dumper.sv
// pkg_dumper: dumper FSM states and the separator characters it emits.
package pkg_dumper;
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, HI, LO, SEP, DONE} dumper_state_t;
    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_LF = 8'h0A;
endpackage

// File: rtl/pkg_ram.sv
// pkg_ram: RAM port operation and access-size types shared by all RAM masters.
package pkg_ram;
    typedef enum logic {RAM_FETCH, RAM_STORE} ram_op_t;
    typedef enum logic [1:0] {RAM_BYTE, RAM_HALF, RAM_WORD} ram_size_t;
endpackage

// File: rtl/hex_ascii.sv
// hex_ascii: one hex nibble to its uppercase ASCII digit.
module hex_ascii (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);
    assign ascii = nibble < 4'd10 ? {4'h3, nibble} : 8'h37 + {4'h0, nibble};
endmodule

// File: rtl/dev_dumper.sv
// dev_dumper: streams a RAM region to the tx pipe as hex text, three characters per byte.
module dev_dumper
    import pkg_ram::*;
    import pkg_dumper::*;
#(
    parameter int BYTES_PER_LINE = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] start_addr,
    input  logic [15:0] len,
    output logic        busy,
    output logic        done,
    output logic [15:0] ram_addr,
    output ram_op_t     ram_op,
    output ram_size_t   ram_size,
    input  logic [7:0]  ram_data_out,
    output logic [7:0]  tx_data_in,
    output logic        tx_push_back,
    input  logic        tx_full
);
    dumper_state_t state, state_nx;
    logic [15:0] addr, remaining;
    logic [7:0] col, byte_q, hex_ch, ch;
    logic [3:0] nib;
    logic last, eol, push_ok, push;
    assign last = remaining == 16'd1;
    assign eol = last || col == 8'(BYTES_PER_LINE - 1);
    // tx_push_back doubles as the "pushed last cycle" flag that spaces pushes apart
    assign push_ok = !tx_full && !tx_push_back;
    assign push = push_ok && state inside {HI, LO, SEP};
    assign ram_addr = addr;
    assign ram_op = RAM_FETCH;
    assign ram_size = RAM_BYTE;
    assign busy = state inside {FETCH, WAIT, HI, LO, SEP};
    assign done = state == DONE;
    assign nib = state == HI ? byte_q[7:4] : byte_q[3:0];
    assign ch = state == SEP ? (eol ? ASCII_LF : ASCII_SP) : hex_ch;
    hex_ascii u_hex (
        .nibble(nib),
        .ascii(hex_ch)
    );
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = len == 16'd0 ? DONE : FETCH;
            FETCH:   state_nx = WAIT;
            WAIT:    state_nx = HI;
            HI:      if (push_ok) state_nx = LO;
            LO:      if (push_ok) state_nx = SEP;
            SEP:     if (push_ok) state_nx = last ? DONE : FETCH;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            addr <= '0;
            remaining <= '0;
            col <= '0;
            byte_q <= '0;
            tx_push_back <= 1'b0;
            tx_data_in <= '0;
        end else begin
            state <= state_nx;
            tx_push_back <= push;
            if (push) tx_data_in <= ch;
            if (state == IDLE && start) begin
                addr <= start_addr;
                remaining <= len;
                col <= '0;
            end
            if (state == WAIT) byte_q <= ram_data_out;
            if (state == SEP && push_ok) begin
                addr <= addr + 16'd1;
                remaining <= remaining - 16'd1;
                col <= eol ? 8'd0 : col + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_dev_dumper.sv
// tb_dev_dumper: directed scoreboard bench for the hex dumper.
module tb_dev_dumper;
    import pkg_ram::*;
    localparam int BPL = 16;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, tx_full = 1'b0;
    logic [15:0] start_addr = '0, len = '0, ram_addr;
    logic [7:0] ram_data_out = '0, tx_data_in;
    logic busy, done, tx_push_back;
    ram_op_t ram_op;
    ram_size_t ram_size;
    logic [7:0] mem [0:65535];
    logic [7:0] exp_q[$], got_q[$], ref_q[$];
    int n_cmp = 0, n_bad = 0, n_push = 0;
    logic last_push = 1'b0;

    dev_dumper #(.BYTES_PER_LINE(BPL)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .len(len),
        .busy(busy), .done(done), .ram_addr(ram_addr), .ram_op(ram_op), .ram_size(ram_size),
        .ram_data_out(ram_data_out), .tx_data_in(tx_data_in), .tx_push_back(tx_push_back),
        .tx_full(tx_full)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ram_data_out <= mem[ram_addr];

    function automatic logic [7:0] hx(logic [3:0] n);
        return n < 4'd10 ? 8'h30 + 8'(n) : 8'h41 + 8'(n) - 8'd10;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        logic full_e;
        full_e = tx_full;
        @(negedge clk);
        if (tx_push_back) begin
            n_push++;
            got_q.push_back(tx_data_in);
            check("push_while_full", full_e, 0);
            check("push_gap", last_push, 0);
            check("queue_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("char", tx_data_in, exp_q.pop_front());
        end
        last_push = tx_push_back;
    endtask

    task automatic start_dump(logic [15:0] a, logic [15:0] l);
        exp_q.delete();
        got_q.delete();
        n_push = 0;
        for (int i = 0; i < int'(l); i++) begin
            logic [7:0] b;
            b = mem[16'(int'(a) + i)];
            exp_q.push_back(hx(b[7:4]));
            exp_q.push_back(hx(b[3:0]));
            exp_q.push_back((i == int'(l) - 1 || (i + 1) % BPL == 0) ? 8'h0A : 8'h20);
        end
        start = 1'b1;
        start_addr = a;
        len = l;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(int max, string tag);
        int k;
        k = 0;
        while (!done && k < max) begin
            tick();
            k++;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_at_done"}, busy, 0);
        tick();
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        int k, np;
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);
        mem[0] = 8'h0A; mem[1] = 8'hFF; mem[2] = 8'h5C;
        mem[16'hFFFF] = 8'hE7;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_push", tx_push_back, 0);
        check("rst_data", tx_data_in, 0);
        check("rst_addr", ram_addr, 0);
        check("ram_op", ram_op, RAM_FETCH);
        check("ram_size", ram_size, RAM_BYTE);
        rst = 1'b0;

        start_dump(16'h0000, 16'd3);
        check("basic_busy", busy, 1);
        tick();
        check("basic_no_early_push", tx_push_back, 0);
        tick();
        check("basic_no_early_push2", tx_push_back, 0);
        tick();
        check("basic_latency", tx_push_back, 1);
        wait_done(200, "basic");
        check("basic_pushes", n_push, 9);
        check("basic_c0", got_q[0], 8'h30);
        check("basic_c1", got_q[1], 8'h41);
        check("basic_c8", got_q[8], 8'h0A);

        start_dump(16'h0100, 16'd17);
        wait_done(1000, "line");
        check("line_pushes", n_push, 51);
        check("line_sp15", got_q[44], 8'h20);
        check("line_lf16", got_q[47], 8'h0A);
        check("line_lf17", got_q[50], 8'h0A);

        start_dump(16'h0200, 16'd5);
        wait_done(500, "ref");
        ref_q = got_q;
        start_dump(16'h0200, 16'd5);
        k = 0;
        while (n_push < 4 && k < 100) begin
            tick();
            k++;
        end
        check("stall_reach", n_push, 4);
        tx_full = 1'b1;
        np = n_push;
        repeat (10) tick();
        check("stall_hold", n_push, np);
        tx_full = 1'b0;
        wait_done(500, "stall");
        check("stall_len", got_q.size(), ref_q.size());
        for (int i = 0; i < ref_q.size() && i < got_q.size(); i++) check("stall_same", got_q[i], ref_q[i]);

        start_dump(16'hFFFF, 16'd2);
        wait_done(200, "wrap");
        check("wrap_c0", got_q[0], 8'h45);
        check("wrap_c1", got_q[1], 8'h37);
        check("wrap_c3", got_q[3], 8'h30);
        check("wrap_c4", got_q[4], 8'h41);

        start_dump(16'h0000, 16'd0);
        wait_done(1, "zero");
        check("zero_pushes", n_push, 0);

        start_dump(16'h0300, 16'd4);
        repeat (5) tick();
        start = 1'b1;
        start_addr = 16'h1234;
        len = 16'd9;
        tick();
        start = 1'b0;
        wait_done(500, "restart");
        check("restart_pushes", n_push, 12);

        start_dump(16'h0400, 16'd2);
        k = 0;
        while (n_push < 1 && k < 50) begin
            tick();
            k++;
        end
        check("mid_reach", n_push, 1);
        rst = 1'b1;
        tick();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_push", tx_push_back, 0);
        check("mid_rst_addr", ram_addr, 0);
        check("mid_rst_data", tx_data_in, 0);
        rst = 1'b0;
        start_dump(16'h0001, 16'd1);
        check("post_rst_busy", busy, 1);
        wait_done(200, "post_rst");
        check("post_rst_pushes", n_push, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dev_dumper.md
DEV_DUMPER -- requirements
Module: dev_dumper

Interface
REQ-001 Parameter BYTES_PER_LINE, default 16: bytes printed per text line; legal range 1..255.
REQ-002 Port clk  in  1  single clock; every flop is updated on its rising edge.
REQ-003 Port rst  in  1  synchronous, active-high reset.
REQ-004 Port start  in  1  one-cycle request to dump; sampled only in IDLE.
REQ-005 Port start_addr  in  16  first RAM byte address of the dump.
REQ-006 Port len  in  16  number of bytes to dump.
REQ-007 Port busy  out  1  high from the cycle after an accepted start until done is asserted.
REQ-008 Port done  out  1  one-cycle pulse when the final character has been pushed.
REQ-009 Port ram_addr  out  16  RAM byte address.
REQ-010 Port ram_op  out  pkg_ram op type  always RAM_FETCH; the dumper never writes RAM.
REQ-011 Port ram_size  out  pkg_ram size type  always RAM_BYTE.
REQ-012 Port ram_data_out  in  8  fetched byte; valid one cycle after ram_addr is presented.
REQ-013 Port tx_data_in  out  8  ASCII character for the tx pipe.
REQ-014 Port tx_push_back  out  1  one-cycle push strobe to the tx pipe.
REQ-015 Port tx_full  in  1  tx pipe full; no push is issued while it is high.

Function
REQ-016 The FSM shall have exactly these states: IDLE, FETCH, WAIT, HI, LO, SEP, DONE.
REQ-017 Transitions from IDLE:
- start=1 and len!=0: latch start_addr and len, go to FETCH.
- start=1 and len=0: go to DONE with no characters pushed.
REQ-018 FETCH: drive ram_addr = current address, then go to WAIT.
REQ-019 WAIT: capture ram_data_out into a byte register, then go to HI.
REQ-020 HI: push the high nibble; LO: push the low nibble.
- Nibble encoding: 0-9 -> 0x30-0x39; A-F uppercase -> 0x41-0x46.
REQ-021 SEP: push a separator, then go to FETCH, or to DONE after the last byte.
- 0x0A after every BYTES_PER_LINE-th byte of a line and after the last byte.
- 0x20 otherwise.
REQ-022 A push shall occur only when tx_full=0 and tx_push_back was 0 in the previous cycle.
- Pushes are therefore at least 2 cycles apart.
- While tx_full=1, the state, tx_data_in and the byte register shall hold.
REQ-023 tx_data_in shall be stable in the cycle tx_push_back=1.
REQ-024 Each byte shall produce exactly 3 pushes, so a dump emits exactly 3*len characters.
REQ-025 The address counter shall increment by 1 per byte and wrap from 0xFFFF to 0x0000.
REQ-026 The remaining-byte counter shall be 16 bits; the column counter shall be 8 bits and clear after each 0x0A.
REQ-027 DONE: assert done for one cycle, deassert busy, return to IDLE.
REQ-028 start while busy=1 shall be ignored, with no effect on the dump in progress.
REQ-029 Latency from accepted start to the first tx_push_back shall be 4 cycles when tx_full=0.

Reset
REQ-030 rst=1 shall force IDLE on the next edge, including mid-dump.
- Cleared to 0: busy, done, tx_push_back, tx_data_in, ram_addr, all counters.
- Any partial character output is abandoned.
REQ-031 On the first cycle after rst falls, the block shall accept a start.

Structure
REQ-032 The state enum and the ASCII constants (0x20, 0x0A) shall live in a new package pkg_dumper.
- RAM op and size types shall come from pkg_ram.
REQ-033 Nibble-to-ASCII conversion shall be a combinational sub-module, hex_ascii (4-bit in, 8-bit out).
REQ-034 At top level, a mux shall select the RAM port (loader vs. CU vs. dumper) and the TX pipe owner.
- The dumper itself shall contain no arbitration.

Verification
REQ-035 start_addr=0x0000, len=3, RAM bytes 0x0A,0xFF,0x5C, tx_full=0 -> characters "0A FF 5C\n", then a 1-cycle done pulse.
REQ-036 len=17, BYTES_PER_LINE=16 -> 0x0A after byte 16 and after byte 17; 51 pushes total.
REQ-037 tx_full held high for 10 cycles mid-dump -> no push while high, no character lost or duplicated, and output identical to the unstalled run.
REQ-038 start_addr=0xFFFF, len=2 -> RAM reads at 0xFFFF then 0x0000.
REQ-039 start with len=0 -> done within 2 cycles and zero pushes.
- A second start pulse during a len=4 dump is ignored.
REQ-040 rst asserted between the HI and LO pushes -> next cycle IDLE, tx_push_back=0, busy=0.
- A following start with len=1 produces a correct 3-character dump.
